ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//   Execute stage plus EX/MEM pipeline register for the RV32I core. Consumes the
//   decoded instruction held by id_ex; computes ALU result, memory address and
//   branch/jump outcome. Registers results toward the MEM stage. Drives the
//   combinational jump redirect back to pc/if_id/id_ex and the EX forwarding path to ID.
// PARAMETERS
//   XLEN      32   datapath width; only 32 supported
//   Op widths come from `OpCodeLen / `OpSelLen in the defines header.
// PORTS
//   clk            in   1          core clock, rising edge
//   rst            in   1          asynchronous reset, active-high
//   r1_i, r2_i     in   32 each    operand A; operand B (ID puts I-type imm here)
//   imm_i          in   32         offset for branch/JAL/JALR/load/store/LUI/AUIPC
//   pc_i           in   32         pc of the instruction in EX
//   rd_i           in   5          destination register
//   rd_enable_i    in   1          destination write request
//   aluop_i        in   OpCodeLen  operation; 0 = NOP/bubble
//   alusel_i       in   OpSelLen   operation class
//   stall_signal   in   5          [3] EX held, [4] MEM held
//   rd_o           out  5          registered rd toward MEM
//   rd_enable_o    out  1          registered write enable; 0 when rd==0
//   wdata_o        out  32         registered ALU/link result
//   mem_addr_o     out  32         registered load/store address
//   mem_wdata_o    out  32         registered store data (r2)
//   aluop_o        out  OpCodeLen  registered op, for MEM width/sign decode
//   alusel_o       out  OpSelLen   registered class
//   jump_flag_o    out  1          comb: taken branch/jump, redirect now
//   jump_target_o  out  32         comb: redirect address
//   fwd_enable_o   out  1          comb: EX result forwardable to ID
//   fwd_rd_o       out  5          comb: rd of instruction in EX
//   fwd_data_o     out  32         comb: EX result
//   ex_is_load_o   out  1          comb: instruction in EX is a load (load-use stall)
// BEHAVIOUR
//   - Reset (async, any time): every registered output 0 (NOP bubble). Comb outputs then follow id_ex zeros: all 0.
//   - Arithmetic mod 2^32. ADD/SUB/AND/OR/XOR on r1_i,r2_i. SLT signed, SLTU unsigned -> 0/1.
//     SLL/SRL/SRA shift amount = r2_i[4:0]; SRA sign-fills.
//   - LUI: result = imm_i. AUIPC: result = pc_i+imm_i.
//   - JAL: target pc_i+imm_i. JALR: target (r1_i+imm_i) & ~1. Both: result pc_i+4, always taken.
//   - BEQ/BNE/BLT/BGE (signed), BLTU/BGEU (unsigned): compare r1_i,r2_i; target pc_i+imm_i; no rd write.
//   - Load/store: mem_addr = r1_i+imm_i; mem_wdata = r2_i; load result 0 (MEM supplies data); stores write no rd.
//   - rd_enable forced 0 when rd_i==0; fwd_enable_o follows same rule; ex_is_load_o = class LOAD.
//   - jump_flag_o = taken && !stall_signal[3]; redirect asserts on the cycle EX leaves.
//   - jump_target_o meaningful only when jump_flag_o=1, else 0.
//   - Register update, priority high->low at posedge clk:
//       stall_signal[4]: hold all registered outputs;
//       stall_signal[3]: load bubble (all 0);
//       else: capture computed values.
//   - Latency: result visible on registered outputs 1 cycle after id_ex presents it.
//     Forwarding and redirect are same-cycle (combinational).
//   - Unknown aluop: treated as NOP, all results 0, no jump.
// TESTING
//   1 ADD r1=0x7FFFFFFF r2=1 rd=5 -> next cycle wdata_o=0x80000000, rd_o=5, rd_enable_o=1.
//   2 SRA r1=0x80000010 r2=0x24 -> wdata_o=0xF8000001; SLTU r1=1 r2=0xFFFFFFFF -> wdata_o=1.
//   3 JALR pc=0x100 r1=0x203 imm=4 rd=1 -> same cycle jump_flag_o=1, target 0x206; next wdata_o=0x104.
//   4 BNE r1=r2=3 -> jump_flag_o=0; BLT r1=0xFFFFFFFF r2=0 pc=0x40 imm=-8 -> flag=1, target 0x38, rd_enable_o=0.
//   5 ADD rd=0 with stall[4]=1 then stall[3]=1 -> outputs held one cycle, then bubble zeros; rd_enable_o never 1.
//   6 LW r1=0x1000 imm=0x10, assert rst mid-cycle -> outputs 0 immediately; without rst mem_addr_o=0x1010, ex_is_load_o=1.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage and EX/MEM pipeline register for the RV32I core.
// Computes ALU/link results, memory address and branch/jump outcome,
// drives the same-cycle redirect and forwarding paths, and registers
// results toward MEM.
`ifndef OpCodeLen
`define OpCodeLen 8
`endif
`ifndef OpSelLen
`define OpSelLen 3
`endif

module ex_stage #(
  parameter int XLEN = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           r1_i,
  input  logic [31:0]           r2_i,
  input  logic [31:0]           imm_i,
  input  logic [31:0]           pc_i,
  input  logic [4:0]            rd_i,
  input  logic                  rd_enable_i,
  input  logic [`OpCodeLen-1:0] aluop_i,
  input  logic [`OpSelLen-1:0]  alusel_i,
  input  logic [4:0]            stall_signal,
  output logic [4:0]            rd_o,
  output logic                  rd_enable_o,
  output logic [31:0]           wdata_o,
  output logic [31:0]           mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic [`OpCodeLen-1:0] aluop_o,
  output logic [`OpSelLen-1:0]  alusel_o,
  output logic                  jump_flag_o,
  output logic [31:0]           jump_target_o,
  output logic                  fwd_enable_o,
  output logic [4:0]            fwd_rd_o,
  output logic [31:0]           fwd_data_o,
  output logic                  ex_is_load_o
);

  typedef logic [`OpCodeLen-1:0] op_t;
  localparam op_t OP_NOP  = op_t'(0);
  localparam op_t OP_ADD  = op_t'(1);
  localparam op_t OP_SUB  = op_t'(2);
  localparam op_t OP_AND  = op_t'(3);
  localparam op_t OP_OR   = op_t'(4);
  localparam op_t OP_XOR  = op_t'(5);
  localparam op_t OP_SLT  = op_t'(6);
  localparam op_t OP_SLTU = op_t'(7);
  localparam op_t OP_SLL  = op_t'(8);
  localparam op_t OP_SRL  = op_t'(9);
  localparam op_t OP_SRA  = op_t'(10);
  localparam op_t OP_LUI  = op_t'(11);
  localparam op_t OP_AUIPC= op_t'(12);
  localparam op_t OP_JAL  = op_t'(13);
  localparam op_t OP_JALR = op_t'(14);
  localparam op_t OP_BEQ  = op_t'(15);
  localparam op_t OP_BNE  = op_t'(16);
  localparam op_t OP_BLT  = op_t'(17);
  localparam op_t OP_BGE  = op_t'(18);
  localparam op_t OP_BLTU = op_t'(19);
  localparam op_t OP_BGEU = op_t'(20);
  localparam op_t OP_LB   = op_t'(21);
  localparam op_t OP_LH   = op_t'(22);
  localparam op_t OP_LW   = op_t'(23);
  localparam op_t OP_LBU  = op_t'(24);
  localparam op_t OP_LHU  = op_t'(25);
  localparam op_t OP_SB   = op_t'(26);
  localparam op_t OP_SH   = op_t'(27);
  localparam op_t OP_SW   = op_t'(28);

  localparam logic [`OpSelLen-1:0] SEL_LOAD = `OpSelLen'(6);

  logic        valid;
  logic        wen;
  logic        taken;
  logic        is_load;
  logic [31:0] res;
  logic [31:0] target;
  logic [31:0] maddr;
  logic [31:0] mwdata;
  logic        wen_final;
  logic [31:0] br_target;
  logic [31:0] mem_sum;

  assign br_target = pc_i + imm_i;
  assign mem_sum   = r1_i + imm_i;

  // Decode aluop and compute result, address and branch outcome.
  always_comb begin
    valid   = 1'b1;
    wen     = 1'b0;
    taken   = 1'b0;
    is_load = 1'b0;
    res     = '0;
    target  = '0;
    maddr   = '0;
    mwdata  = '0;
    case (aluop_i)
      OP_ADD:   begin res = r1_i + r2_i; wen = 1'b1; end
      OP_SUB:   begin res = r1_i - r2_i; wen = 1'b1; end
      OP_AND:   begin res = r1_i & r2_i; wen = 1'b1; end
      OP_OR:    begin res = r1_i | r2_i; wen = 1'b1; end
      OP_XOR:   begin res = r1_i ^ r2_i; wen = 1'b1; end
      OP_SLT:   begin res = {31'b0, $signed(r1_i) < $signed(r2_i)}; wen = 1'b1; end
      OP_SLTU:  begin res = {31'b0, r1_i < r2_i}; wen = 1'b1; end
      OP_SLL:   begin res = r1_i << r2_i[4:0]; wen = 1'b1; end
      OP_SRL:   begin res = r1_i >> r2_i[4:0]; wen = 1'b1; end
      OP_SRA:   begin res = $signed(r1_i) >>> r2_i[4:0]; wen = 1'b1; end
      OP_LUI:   begin res = imm_i; wen = 1'b1; end
      OP_AUIPC: begin res = br_target; wen = 1'b1; end
      OP_JAL:   begin res = pc_i + 32'd4; wen = 1'b1; taken = 1'b1; target = br_target; end
      OP_JALR:  begin res = pc_i + 32'd4; wen = 1'b1; taken = 1'b1; target = mem_sum & ~32'd1; end
      OP_BEQ:   begin taken = (r1_i == r2_i); target = br_target; end
      OP_BNE:   begin taken = (r1_i != r2_i); target = br_target; end
      OP_BLT:   begin taken = ($signed(r1_i) <  $signed(r2_i)); target = br_target; end
      OP_BGE:   begin taken = ($signed(r1_i) >= $signed(r2_i)); target = br_target; end
      OP_BLTU:  begin taken = (r1_i <  r2_i); target = br_target; end
      OP_BGEU:  begin taken = (r1_i >= r2_i); target = br_target; end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        maddr   = mem_sum;
        wen     = 1'b1;
        is_load = (alusel_i == SEL_LOAD);
      end
      OP_SB, OP_SH, OP_SW: begin maddr = mem_sum; mwdata = r2_i; end
      default:  valid = 1'b0;  // OP_NOP and unknown codes behave as a bubble
    endcase
  end

  assign wen_final     = valid && wen && rd_enable_i && (rd_i != 5'd0);
  assign jump_flag_o   = taken && !stall_signal[3];
  assign jump_target_o = jump_flag_o ? target : 32'd0;
  assign fwd_enable_o  = wen_final;
  assign fwd_rd_o      = valid ? rd_i : 5'd0;
  assign fwd_data_o    = res;
  assign ex_is_load_o  = is_load;

  // EX/MEM register: MEM stall holds, EX stall inserts a bubble, else capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_o        <= '0;
      rd_enable_o <= 1'b0;
      wdata_o     <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      aluop_o     <= '0;
      alusel_o    <= '0;
    end else if (stall_signal[4]) begin
      rd_o        <= rd_o;
      rd_enable_o <= rd_enable_o;
      wdata_o     <= wdata_o;
      mem_addr_o  <= mem_addr_o;
      mem_wdata_o <= mem_wdata_o;
      aluop_o     <= aluop_o;
      alusel_o    <= alusel_o;
    end else if (stall_signal[3] || !valid) begin
      rd_o        <= '0;
      rd_enable_o <= 1'b0;
      wdata_o     <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      aluop_o     <= '0;
      alusel_o    <= '0;
    end else begin
      rd_o        <= rd_i;
      rd_enable_o <= wen_final;
      wdata_o     <= res;
      mem_addr_o  <= maddr;
      mem_wdata_o <= mwdata;
      aluop_o     <= aluop_i;
      alusel_o    <= alusel_i;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage with hand-computed expectations.
`ifndef OpCodeLen
`define OpCodeLen 8
`endif
`ifndef OpSelLen
`define OpSelLen 3
`endif

module tb_ex_stage;
  logic                  clk = 1'b0;
  logic                  rst;
  logic [31:0]           r1_i, r2_i, imm_i, pc_i;
  logic [4:0]            rd_i;
  logic                  rd_enable_i;
  logic [`OpCodeLen-1:0] aluop_i;
  logic [`OpSelLen-1:0]  alusel_i;
  logic [4:0]            stall_signal;
  logic [4:0]            rd_o;
  logic                  rd_enable_o;
  logic [31:0]           wdata_o, mem_addr_o, mem_wdata_o;
  logic [`OpCodeLen-1:0] aluop_o;
  logic [`OpSelLen-1:0]  alusel_o;
  logic                  jump_flag_o;
  logic [31:0]           jump_target_o;
  logic                  fwd_enable_o;
  logic [4:0]            fwd_rd_o;
  logic [31:0]           fwd_data_o;
  logic                  ex_is_load_o;

  int vectors = 0;
  int miscompares = 0;

  ex_stage dut (
    .clk(clk), .rst(rst), .r1_i(r1_i), .r2_i(r2_i), .imm_i(imm_i), .pc_i(pc_i),
    .rd_i(rd_i), .rd_enable_i(rd_enable_i), .aluop_i(aluop_i), .alusel_i(alusel_i),
    .stall_signal(stall_signal), .rd_o(rd_o), .rd_enable_o(rd_enable_o),
    .wdata_o(wdata_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .aluop_o(aluop_o), .alusel_o(alusel_o), .jump_flag_o(jump_flag_o),
    .jump_target_o(jump_target_o), .fwd_enable_o(fwd_enable_o), .fwd_rd_o(fwd_rd_o),
    .fwd_data_o(fwd_data_o), .ex_is_load_o(ex_is_load_o)
  );

  always #5 clk = ~clk;

  // Opcode / class encodings of the core's defines header.
  localparam logic [7:0] ADD = 8'd1, SLTU = 8'd7, SRA = 8'd10, JAL = 8'd13, JALR = 8'd14,
                         BNE = 8'd16, BLT = 8'd17, LW = 8'd23, SW = 8'd28;
  localparam logic [2:0] C_ARITH = 3'd1, C_SHIFT = 3'd3, C_JUMP = 3'd4, C_BRANCH = 3'd5,
                         C_LOAD = 3'd6, C_STORE = 3'd7;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present an instruction from id_ex just after the falling edge.
  task automatic apply(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] imm, input logic [31:0] pc,
                       input logic [4:0] rd, input logic [4:0] stall);
    @(negedge clk);
    aluop_i = op; alusel_i = sel; r1_i = r1; r2_i = r2; imm_i = imm; pc_i = pc;
    rd_i = rd; rd_enable_i = 1'b1; stall_signal = stall;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    r1_i = '0; r2_i = '0; imm_i = '0; pc_i = '0; rd_i = '0; rd_enable_i = 1'b0;
    aluop_i = '0; alusel_i = '0; stall_signal = '0;
    #12;
    chk("reset wdata", wdata_o, 32'h0);
    chk("reset rd_en", {31'b0, rd_enable_o}, 32'h0);
    chk("reset aluop", {24'b0, aluop_o}, 32'h0);
    chk("reset jump", {31'b0, jump_flag_o}, 32'h0);
    chk("reset fwd_en", {31'b0, fwd_enable_o}, 32'h0);
    @(negedge clk); rst = 1'b0;

    // ADD overflow wraps
    apply(ADD, C_ARITH, 32'h7FFFFFFF, 32'h1, 0, 0, 5'd5, 5'd0);
    chk("add fwd_data", fwd_data_o, 32'h80000000);
    chk("add fwd_en", {31'b0, fwd_enable_o}, 32'h1);
    tick();
    chk("add wdata", wdata_o, 32'h80000000);
    chk("add rd", {27'b0, rd_o}, 32'd5);
    chk("add rd_en", {31'b0, rd_enable_o}, 32'h1);
    chk("add aluop_o", {24'b0, aluop_o}, 32'd1);

    apply(SRA, C_SHIFT, 32'h80000010, 32'h24, 0, 0, 5'd6, 5'd0);
    tick();
    chk("sra wdata", wdata_o, 32'hF8000001);
    apply(SLTU, C_ARITH, 32'h1, 32'hFFFFFFFF, 0, 0, 5'd6, 5'd0);
    tick();
    chk("sltu wdata", wdata_o, 32'h1);

    apply(JALR, C_JUMP, 32'h203, 0, 32'h4, 32'h100, 5'd1, 5'd0);
    chk("jalr flag", {31'b0, jump_flag_o}, 32'h1);
    chk("jalr target", jump_target_o, 32'h206);
    tick();
    chk("jalr link", wdata_o, 32'h104);

    // Redirect suppressed while EX is held; register gets a bubble
    apply(JAL, C_JUMP, 0, 0, 32'h20, 32'h200, 5'd1, 5'b01000);
    chk("jal stalled flag", {31'b0, jump_flag_o}, 32'h0);
    chk("jal stalled target", jump_target_o, 32'h0);
    tick();
    chk("jal stalled bubble", wdata_o, 32'h0);

    apply(BNE, C_BRANCH, 32'h3, 32'h3, 32'h10, 32'h40, 5'd0, 5'd0);
    chk("bne flag", {31'b0, jump_flag_o}, 32'h0);
    apply(BLT, C_BRANCH, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFF8, 32'h40, 5'd7, 5'd0);
    chk("blt flag", {31'b0, jump_flag_o}, 32'h1);
    chk("blt target", jump_target_o, 32'h38);
    tick();
    chk("blt rd_en", {31'b0, rd_enable_o}, 32'h0);

    // rd=0: never a write; MEM stall holds, EX stall bubbles
    apply(ADD, C_ARITH, 32'h5, 32'h5, 0, 0, 5'd0, 5'd0);
    chk("rd0 fwd_en", {31'b0, fwd_enable_o}, 32'h0);
    tick();
    chk("rd0 wdata", wdata_o, 32'd10);
    chk("rd0 rd_en", {31'b0, rd_enable_o}, 32'h0);
    apply(ADD, C_ARITH, 32'h1, 32'h1, 0, 0, 5'd0, 5'b10000);
    tick();
    chk("mem stall hold", wdata_o, 32'd10);
    chk("mem stall rd_en", {31'b0, rd_enable_o}, 32'h0);
    apply(ADD, C_ARITH, 32'h1, 32'h1, 0, 0, 5'd0, 5'b01000);
    tick();
    chk("ex stall bubble", wdata_o, 32'h0);
    chk("ex stall rd_en", {31'b0, rd_enable_o}, 32'h0);

    apply(SW, C_STORE, 32'h2000, 32'hDEADBEEF, 32'h8, 0, 5'd9, 5'd0);
    tick();
    chk("sw addr", mem_addr_o, 32'h2008);
    chk("sw data", mem_wdata_o, 32'hDEADBEEF);
    chk("sw rd_en", {31'b0, rd_enable_o}, 32'h0);

    apply(8'h3F, C_ARITH, 32'h1, 32'h1, 0, 0, 5'd4, 5'd0);
    chk("unknown fwd_en", {31'b0, fwd_enable_o}, 32'h0);
    chk("unknown jump", {31'b0, jump_flag_o}, 32'h0);
    tick();
    chk("unknown wdata", wdata_o, 32'h0);
    chk("unknown rd_en", {31'b0, rd_enable_o}, 32'h0);

    apply(LW, C_LOAD, 32'h1000, 0, 32'h10, 0, 5'd8, 5'd0);
    chk("lw is_load", {31'b0, ex_is_load_o}, 32'h1);
    tick();
    chk("lw addr", mem_addr_o, 32'h1010);
    chk("lw wdata", wdata_o, 32'h0);
    chk("lw rd_en", {31'b0, rd_enable_o}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async rst addr", mem_addr_o, 32'h0);
    chk("async rst rd_en", {31'b0, rd_enable_o}, 32'h0);
    chk("async rst aluop", {24'b0, aluop_o}, 32'h0);
    @(negedge clk); rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
